// File: rtl/wrr_arbiter.sv
// wrr_arbiter: parametrised weighted round-robin arbiter.
// A winner keeps the grant for up to weight[i] accepted beats, then priority
// rotates past it. Grant is combinational from req and the registered state.
// Optional feature macro: WRR_ARB_LOCK_EN adds the lock input, which holds a
// burst past its credit until an accept arrives with lock low.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no burst in progress; search starts at ptr
// BURST | owner holds the grant while it requests; credit beats remain
module wrr_arbiter #(
    parameter int N  = 4,
    parameter int WW = 4,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            update_en,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weight,
`ifdef WRR_ARB_LOCK_EN
    input  logic            lock,
`endif
    output logic [N-1:0]    gnt,
    output logic [IW-1:0]   gnt_id,
    output logic            any_gnt
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} st_t;

    st_t           st;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic [WW-1:0] credit;

    logic          lock_i;
    logic          owner_hold;
    logic [IW-1:0] base;
    logic          found;
    logic [IW-1:0] win;
    logic [IW:0]   sum;
    logic [WW-1:0] wsel;
    logic          accept;

`ifdef WRR_ARB_LOCK_EN
    assign lock_i = lock;
`else
    assign lock_i = 1'b0;
`endif

    // Modulo-N increment: N-1 wraps to 0 even when N is not a power of two.
    function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] v);
        return (v == IW'(N - 1)) ? '0 : v + IW'(1);
    endfunction

    assign owner_hold = (st == BURST) && req[owner];
    assign base       = (st == BURST) ? inc_mod(owner) : ptr;

    // Find the first requester at or after base, wrapping N-1 -> 0.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, base} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            if (!found && req[sum[IW-1:0]]) begin
                found = 1'b1;
                win   = sum[IW-1:0];
            end
        end
    end

    // Drive outputs; everything is forced low while in reset or disabled.
    always_comb begin
        any_gnt = reset && en && (owner_hold || found);
        gnt_id  = '0;
        gnt     = '0;
        if (any_gnt) begin
            gnt_id      = owner_hold ? owner : win;
            gnt[gnt_id] = 1'b1;
        end
    end

    // Weight of the current winner, only consumed on an IDLE-style accept.
    always_comb begin
        wsel = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_id == IW'(i)) begin
                wsel = weight[i*WW +: WW];
            end
        end
    end

    assign accept = en && update_en && any_gnt;

    // Burst state machine; frozen entirely while en is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st     <= IDLE;
            ptr    <= '0;
            owner  <= '0;
            credit <= '0;
        end else if (en) begin
            if (owner_hold) begin
                if (accept) begin
                    if (credit > WW'(1)) begin
                        credit <= credit - WW'(1);
                    end else if (lock_i) begin
                        credit <= '0;
                    end else begin
                        credit <= '0;
                        st     <= IDLE;
                        ptr    <= inc_mod(owner);
                    end
                end
            end else if (accept) begin
                // Fresh win from IDLE, or a new winner after the owner dropped.
                if (wsel <= WW'(1)) begin
                    st     <= IDLE;
                    ptr    <= inc_mod(gnt_id);
                    credit <= '0;
                end else begin
                    st     <= BURST;
                    owner  <= gnt_id;
                    credit <= wsel - WW'(1);
                end
            end else if (st == BURST) begin
                // Owner dropped its request and nobody was accepted.
                st     <= IDLE;
                ptr    <= inc_mod(owner);
                credit <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
// tb_wrr_arbiter: directed tests for wrr_arbiter (N=4 instance plus an N=3 instance).
module tb_wrr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        update_en;
    logic [3:0]  req;
    logic [15:0] weight;
    logic        lock;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        any_gnt;

    logic [2:0]  req3;
    logic [11:0] weight3;
    logic [2:0]  gnt3;
    logic [1:0]  gnt_id3;
    logic        any_gnt3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wrr_arbiter #(.N(4), .WW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .update_en (update_en),
        .req       (req),
        .weight    (weight),
`ifdef WRR_ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .any_gnt   (any_gnt)
    );

    wrr_arbiter #(.N(3), .WW(4)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .update_en (update_en),
        .req       (req3),
        .weight    (weight3),
`ifdef WRR_ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt3),
        .gnt_id    (gnt_id3),
        .any_gnt   (any_gnt3)
    );

    // Advance one clock; returns just after the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        en        = 1'b1;
        update_en = 1'b0;
        req       = '0;
        req3      = '0;
        lock      = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset     = 1'b0;
        en        = 1'b1;
        update_en = 1'b1;
        req       = 4'b1111;
        weight    = 16'h1111;
        #1;
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_gnt: got %b expected 0000", gnt);
        end
        n_checks++;
        if (gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_gnt_id: got %0d expected 0", gnt_id);
        end
        n_checks++;
        if (any_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_any_gnt: got %b expected 0", any_gnt);
        end
        cyc();
        reset = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_release_gnt: got %b expected 0001", gnt);
        end
    endtask

    task automatic test_rr_equal();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        weight    = 16'h1111;
        req       = 4'b1111;
        update_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (gnt !== exp_g[i]) begin
                n_fail++;
                $display("FAIL rr_equal[%0d]: got %b expected %b", i, gnt, exp_g[i]);
            end
            cyc();
        end
    endtask

    // w0=2, w1=1, w2=3, w3=1
    task automatic test_weighted();
        logic [1:0] exp_id [9] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0};
        do_reset();
        weight    = {4'd1, 4'd3, 4'd1, 4'd2};
        req       = 4'b1111;
        update_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            n_checks++;
            if (gnt_id !== exp_id[i] || any_gnt !== 1'b1) begin
                n_fail++;
                $display("FAIL weighted[%0d]: got id %0d any %b expected id %0d any 1",
                         i, gnt_id, any_gnt, exp_id[i]);
            end
            cyc();
        end
    endtask

    task automatic test_non_pow2();
        logic [1:0] exp_id [6] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
        logic [2:0] exp_g  [6] = '{3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100};
        do_reset();
        weight3   = 12'h111;
        req3      = 3'b101;
        update_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++;
            if (gnt_id3 !== exp_id[i] || gnt3 !== exp_g[i]) begin
                n_fail++;
                $display("FAIL non_pow2[%0d]: got id %0d gnt %b expected id %0d gnt %b",
                         i, gnt_id3, gnt3, exp_id[i], exp_g[i]);
            end
            cyc();
        end
        req3 = '0;
    endtask

    task automatic test_burst_drop();
        do_reset();
        weight    = {4'd1, 4'd1, 4'd1, 4'd4};
        req       = 4'b0011;
        update_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (gnt !== 4'b0001) begin
                n_fail++;
                $display("FAIL drop_burst[%0d]: got %b expected 0001", i, gnt);
            end
            cyc();
        end
        req       = 4'b0010;
        update_en = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL drop_same_cycle: got %b expected 0010", gnt);
        end
        cyc();
        req       = 4'b0011;
        update_en = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL drop_ptr_r1_first: got %b expected 0010", gnt);
        end
        cyc();
        #1;
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL drop_r0_after_r1: got %b expected 0001", gnt);
        end
    endtask

    task automatic test_en_freeze();
        logic [3:0] exp_g [3] = '{4'b0001, 4'b0001, 4'b0010};
        do_reset();
        weight    = {4'd1, 4'd1, 4'd3, 4'd4};
        req       = 4'b1111;
        update_en = 1'b1;
        cyc();
        cyc();
        // Two of four beats used; owner drops while disabled, which must not end the burst.
        en  = 1'b0;
        req = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (gnt !== 4'b0000 || any_gnt !== 1'b0) begin
                n_fail++;
                $display("FAIL en_off[%0d]: got gnt %b any %b expected 0000 0", i, gnt, any_gnt);
            end
            cyc();
        end
        en  = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (gnt !== exp_g[i]) begin
                n_fail++;
                $display("FAIL en_resume[%0d]: got %b expected %b", i, gnt, exp_g[i]);
            end
            cyc();
        end
        // r1 is now mid-burst; reset abandons it immediately.
        reset = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 4'b0000 || any_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_burst: got gnt %b any %b expected 0000 0", gnt, any_gnt);
        end
        cyc();
        reset = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_restart: got %b expected 0001", gnt);
        end
    endtask

    task automatic test_idle_update();
        do_reset();
        weight    = {4'd1, 4'd0, 4'd1, 4'd1};
        req       = 4'b1111;
        update_en = 1'b1;
        cyc();
        cyc();
        req = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (any_gnt !== 1'b0 || gnt_id !== 2'd0) begin
                n_fail++;
                $display("FAIL idle_no_req[%0d]: got any %b id %0d expected 0 0", i, any_gnt, gnt_id);
            end
            cyc();
        end
        req = 4'b1111;
        #1;
        n_checks++;
        if (gnt_id !== 2'd2) begin
            n_fail++;
            $display("FAIL idle_ptr_kept: got %0d expected 2", gnt_id);
        end
        cyc();
        #1;
        n_checks++;
        if (gnt_id !== 2'd3) begin
            n_fail++;
            $display("FAIL zero_weight_one_beat: got %0d expected 3", gnt_id);
        end
        cyc();
    endtask

`ifdef WRR_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        weight    = {4'd1, 4'd1, 4'd2, 4'd1};
        req       = 4'b0010;
        update_en = 1'b1;
        lock      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (gnt !== 4'b0010) begin
                n_fail++;
                $display("FAIL lock_hold[%0d]: got %b expected 0010", i, gnt);
            end
            cyc();
            req = 4'b0011;
        end
        lock = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL lock_release_beat: got %b expected 0010", gnt);
        end
        cyc();
        #1;
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL lock_next_owner: got %b expected 0001", gnt);
        end
        cyc();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        en        = 1'b0;
        update_en = 1'b0;
        req       = '0;
        weight    = '0;
        req3      = '0;
        weight3   = '0;
        lock      = 1'b0;
        test_reset();
        test_rr_equal();
        test_weighted();
        test_non_pow2();
        test_burst_drop();
        test_en_freeze();
        test_idle_update();
`ifdef WRR_ARB_LOCK_EN
        test_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
